// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter that shares one 4:1 mux between four requesters.
// An owner keeps its grant until it drops its request or the hold timer runs out.
// After every release there is one idle cycle with no grant.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req      in   [3:0] request per requester (bit i = mux input i)
//   sel      out  [1:0] registered mux select; changes only when a new grant is issued
//   grant    out  [3:0] registered one-hot grant, zero when there is no owner
//   busy     out  high while a grant is active (OR of grant)
//   expired  out  one-cycle pulse when the hold timer forces a release
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per owner; 0 = unlimited
//   CNT_W     hold counter width; 2**CNT_W must exceed MAX_HOLD
module mux_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [1:0] sel,
   output logic [3:0] grant,
   output logic       busy,
   output logic       expired
);

   // Counter value seen on the last allowed grant cycle.
   localparam logic [CNT_W-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

   if (CNT_W == 0 || CNT_W > 31 || MAX_HOLD >= (32'd1 << CNT_W)) begin : g_bad_hold
      $error("mux_rr_arbiter: MAX_HOLD does not fit in CNT_W bits");
   end

   typedef enum logic {
      StIdle,
      StGrant
   } state_t;

   state_t           r_state;
   logic [1:0]       r_sel;
   logic [3:0]       r_grant;
   logic [1:0]       r_last;
   logic [CNT_W-1:0] r_cnt;
   logic             r_expired;

   state_t           w_state_nxt;
   logic [1:0]       w_sel_nxt;
   logic [3:0]       w_grant_nxt;
   logic [1:0]       w_last_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_expired_nxt;
   logic [1:0]       w_win;

   // Search last+1, last+2, last+3, last. Scanning from the far end lets the
   // nearest asserted request overwrite the others.
   always_comb begin
      logic [1:0] idx;
      w_win = r_last;
      idx   = r_last;
      for (int k = 4; k >= 1; k--) begin
         idx = r_last + 2'(k);
         if (req[idx]) w_win = idx;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_sel_nxt     = r_sel;
      w_grant_nxt   = r_grant;
      w_last_nxt    = r_last;
      w_cnt_nxt     = r_cnt;
      w_expired_nxt = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (|req) begin
               w_state_nxt = StGrant;
               w_sel_nxt   = w_win;
               w_grant_nxt = 4'b0001 << w_win;
               w_last_nxt  = w_win;
               w_cnt_nxt   = '0;
            end else begin
               w_grant_nxt = 4'b0000;
            end
         end
         StGrant: begin
            if (!req[r_sel]) begin
               // Owner let go; this takes precedence over a coincident timeout.
               w_state_nxt = StIdle;
               w_grant_nxt = 4'b0000;
            end else if (MAX_HOLD != 0 && r_cnt == HoldLast) begin
               w_state_nxt   = StIdle;
               w_grant_nxt   = 4'b0000;
               w_expired_nxt = 1'b1;
            end else if (r_cnt != '1) begin
               // Only the unlimited configuration can reach all ones; it saturates there.
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_grant_nxt = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_sel     <= 2'b00;
         r_grant   <= 4'b0000;
         r_last    <= 2'd3;
         r_cnt     <= '0;
         r_expired <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_sel     <= w_sel_nxt;
         r_grant   <= w_grant_nxt;
         r_last    <= w_last_nxt;
         r_cnt     <= w_cnt_nxt;
         r_expired <= w_expired_nxt;
      end
   end

   assign sel     = r_sel;
   assign grant   = r_grant;
   assign busy    = |r_grant;
   assign expired = r_expired;

endmodule
